bridge_arbiter: RTL and testbench
=================================

BRIDGE_ARBITER -- requirements
Module: bridge_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 16, is the width of request and bus address fields.
REQ-002 Parameter DATA_WIDTH, default 16, is the width of request, response and bus data fields.
REQ-003 Parameter TIMEOUT, default 255, is the maximum number of cycles waited for a read response (1..255).
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 reqN_addr  input  ADDR_WIDTH  port N request address (N = 0, 1).
REQ-007 reqN_data  input  DATA_WIDTH  port N write data.
REQ-008 reqN_rw  input  1  port N direction: 1 = write, 0 = read.
REQ-009 reqN_valid  input  1  port N request pending; held with fields stable until reqN_ready.
REQ-010 reqN_ready  output  1  one-cycle acceptance pulse to port N.
REQ-011 resN_data  output  DATA_WIDTH  read data returned to port N.
REQ-012 resN_valid  output  1  port N read response valid; held until resN_ready.
REQ-013 resN_ready  input  1  port N response consumer ready.
REQ-014 bus_addr_o, bus_data_o, bus_rw_o  output  ADDR_WIDTH/DATA_WIDTH/1  request fields driven into the core chain.
REQ-015 bus_valid_o  output  1  one-cycle strobe qualifying bus_*_o.
REQ-016 bus_data_i, bus_rw_i, bus_valid_i  input  DATA_WIDTH/1/1  response returning from the core chain.
REQ-017 timeout_count  output  8  saturating count of read timeouts since reset.

Function
REQ-018 States are IDLE, ISSUE, WAIT_RESP, DELIVER; all outputs registered.
REQ-019 IDLE: if exactly one reqN_valid is high, that port wins; if both are high, the port not granted last wins; after reset, port 0 is treated as last granted loser (port 0 wins first tie).
REQ-020 On the edge leaving IDLE with a winner: latch winner's addr/data/rw and owner index, drive reqN_ready=1 and bus_valid_o=1 for exactly the following cycle (ISSUE), bus_*_o = latched fields.
REQ-021 Request acceptance latency: req valid sampled in cycle N gives reqN_ready and bus_valid_o in cycle N+1.
REQ-022 ISSUE lasts one cycle; next state is IDLE for a write, WAIT_RESP for a read; the last-granted pointer updates to the owner on leaving ISSUE.
REQ-023 No request is sampled outside IDLE; reqN_valid held during ISSUE/WAIT_RESP/DELIVER is not double-accepted.
REQ-024 WAIT_RESP: a cycle with bus_valid_i=1 and bus_rw_i=0 latches bus_data_i into res<owner>_data and enters DELIVER.
REQ-025 WAIT_RESP: a cycle counter starts at 0 on entry; if it reaches TIMEOUT with no response, res<owner>_data = 0, timeout_count increments (saturating at 255), and state enters DELIVER.
REQ-026 A response and timeout in the same cycle: response wins, no timeout counted.
REQ-027 bus_valid_i with bus_rw_i=1 (write echo) and any bus_valid_i outside WAIT_RESP are ignored.
REQ-028 DELIVER: res<owner>_valid=1, other port's resN_valid=0; on a cycle with res<owner>_ready=1, res<owner>_valid drops on the next edge and state returns to IDLE.
REQ-029 Minimum spacing between consecutive bus_valid_o strobes is 2 cycles; only one transaction outstanding at any time.
REQ-030 bus_*_o fields hold last issued values outside ISSUE; only bus_valid_o qualifies them.

Reset
REQ-031 rst=1 at an edge forces IDLE, all reqN_ready, resN_valid, bus_valid_o = 0, all data/addr outputs = 0, timeout_count = 0, counter = 0, tie pointer to favor port 0, regardless of state (mid-transaction work is dropped).

Verification
REQ-032 Port 0 write addr 0x0012 data 0xBEEF -> one-cycle req0_ready and bus_valid_o next cycle with bus_addr_o=0x0012, bus_data_o=0xBEEF, bus_rw_o=1; IDLE two cycles after sample; no res0_valid.
REQ-033 Port 1 read addr 0x0004, chain returns bus_data_i=0x1234 three cycles after strobe -> res1_valid=1, res1_data=0x1234 held until res1_ready, res0_valid stays 0.
REQ-034 Both ports assert writes same cycle after reset -> port 0 served first, port 1 served next; repeat tie -> port 0 served after port 1 (alternation).
REQ-035 Read with no chain response, TIMEOUT=4 -> res0_valid with res0_data=0 four cycles after entering WAIT_RESP, timeout_count=1; response and timeout coincident -> real data, count unchanged.
REQ-036 rst asserted during WAIT_RESP then released, late bus_valid_i arrives -> ignored, all outputs 0, next request processed normally with port 0 winning a tie.

Source files
------------

// File: rtl/bridge_arbiter.sv
// bridge_arbiter: grants one of two request ports onto a single-outstanding core chain and returns read data.
// Latency: a request sampled in cycle N is strobed on the bus in N+1; read data returns on response or after TIMEOUT wait cycles.
// Backpressure: reqN_valid is held until the one-cycle reqN_ready; resN_valid is held until resN_ready.
module bridge_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_data,
  input  logic                  req0_rw,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  output logic [DATA_WIDTH-1:0] res0_data,
  output logic                  res0_valid,
  input  logic                  res0_ready,

  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_data,
  input  logic                  req1_rw,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  output logic [DATA_WIDTH-1:0] res1_data,
  output logic                  res1_valid,
  input  logic                  res1_ready,

  output logic [ADDR_WIDTH-1:0] bus_addr_o,
  output logic [DATA_WIDTH-1:0] bus_data_o,
  output logic                  bus_rw_o,
  output logic                  bus_valid_o,
  input  logic [DATA_WIDTH-1:0] bus_data_i,
  input  logic                  bus_rw_i,
  input  logic                  bus_valid_i,

  output logic [7:0]            timeout_count
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_RESP = 2'd2,
    DELIVER   = 2'd3
  } state_t;

  // wait_cnt counts completed WAIT_RESP cycles; the cycle in which it holds
  // TIMEOUT-1 is the last one in which a response may still be accepted.
  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_t                  state;
  state_t                  state_nxt;
  logic                    owner;
  logic                    owner_nxt;
  logic                    favor;       // port that wins when both request
  logic                    favor_nxt;
  logic [7:0]              wait_cnt;
  logic [7:0]              wait_cnt_nxt;

  logic [ADDR_WIDTH-1:0]   bus_addr_nxt;
  logic [DATA_WIDTH-1:0]   bus_data_nxt;
  logic                    bus_rw_nxt;
  logic                    bus_valid_nxt;
  logic                    req0_ready_nxt;
  logic                    req1_ready_nxt;
  logic [DATA_WIDTH-1:0]   res0_data_nxt;
  logic [DATA_WIDTH-1:0]   res1_data_nxt;
  logic                    res0_valid_nxt;
  logic                    res1_valid_nxt;
  logic [7:0]              timeout_nxt;

  logic                    any_req;
  logic                    winner;
  logic                    resp_hit;
  logic                    wait_expired;
  logic                    owner_res_ready;
  logic [DATA_WIDTH-1:0]   resp_word;

  // Arbitration: a lone requester wins outright; a tie goes to the favoured port.
  always_comb begin
    any_req = req0_valid | req1_valid;
    winner  = 1'b0;
    if (req0_valid && req1_valid) begin
      winner = favor;
    end else begin
      winner = req1_valid;
    end
  end

  // Response qualification while a read is outstanding; write echoes never count.
  always_comb begin
    resp_hit        = bus_valid_i & ~bus_rw_i;
    wait_expired    = (wait_cnt == LAST_WAIT);
    owner_res_ready = owner ? res1_ready : res0_ready;
    resp_word       = resp_hit ? bus_data_i : '0;
  end

  // Next-state and next-output logic; every registered output is computed here.
  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    favor_nxt      = favor;
    wait_cnt_nxt   = wait_cnt;
    bus_addr_nxt   = bus_addr_o;
    bus_data_nxt   = bus_data_o;
    bus_rw_nxt     = bus_rw_o;
    bus_valid_nxt  = 1'b0;
    req0_ready_nxt = 1'b0;
    req1_ready_nxt = 1'b0;
    res0_data_nxt  = res0_data;
    res1_data_nxt  = res1_data;
    res0_valid_nxt = res0_valid;
    res1_valid_nxt = res1_valid;
    timeout_nxt    = timeout_count;

    case (state)
      IDLE: begin
        if (any_req) begin
          owner_nxt      = winner;
          bus_addr_nxt   = winner ? req1_addr : req0_addr;
          bus_data_nxt   = winner ? req1_data : req0_data;
          bus_rw_nxt     = winner ? req1_rw   : req0_rw;
          bus_valid_nxt  = 1'b1;
          req0_ready_nxt = ~winner;
          req1_ready_nxt = winner;
          state_nxt      = ISSUE;
        end
      end

      ISSUE: begin
        // The port just served loses the next tie.
        favor_nxt    = ~owner;
        wait_cnt_nxt = 8'd0;
        state_nxt    = bus_rw_o ? IDLE : WAIT_RESP;
      end

      WAIT_RESP: begin
        if (resp_hit || wait_expired) begin
          // A response in the final wait cycle beats the timeout.
          if (owner) begin
            res1_data_nxt  = resp_word;
            res1_valid_nxt = 1'b1;
          end else begin
            res0_data_nxt  = resp_word;
            res0_valid_nxt = 1'b1;
          end
          if (!resp_hit && timeout_count != 8'hFF) begin
            timeout_nxt = timeout_count + 8'd1;
          end
          state_nxt = DELIVER;
        end else begin
          wait_cnt_nxt = wait_cnt + 8'd1;
        end
      end

      DELIVER: begin
        if (owner_res_ready) begin
          res0_valid_nxt = 1'b0;
          res1_valid_nxt = 1'b0;
          state_nxt      = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // FSM state, ownership, tie pointer and wait counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      owner    <= 1'b0;
      favor    <= 1'b0;
      wait_cnt <= 8'd0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      favor    <= favor_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Registered outputs toward both ports and the core chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_addr_o    <= '0;
      bus_data_o    <= '0;
      bus_rw_o      <= 1'b0;
      bus_valid_o   <= 1'b0;
      req0_ready    <= 1'b0;
      req1_ready    <= 1'b0;
      res0_data     <= '0;
      res1_data     <= '0;
      res0_valid    <= 1'b0;
      res1_valid    <= 1'b0;
      timeout_count <= 8'd0;
    end else begin
      bus_addr_o    <= bus_addr_nxt;
      bus_data_o    <= bus_data_nxt;
      bus_rw_o      <= bus_rw_nxt;
      bus_valid_o   <= bus_valid_nxt;
      req0_ready    <= req0_ready_nxt;
      req1_ready    <= req1_ready_nxt;
      res0_data     <= res0_data_nxt;
      res1_data     <= res1_data_nxt;
      res0_valid    <= res0_valid_nxt;
      res1_valid    <= res1_valid_nxt;
      timeout_count <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_bridge_arbiter.sv
// tb_bridge_arbiter: randomized and directed traffic on both ports against a queue-based reference model.
// Latency: checks strobe/response timing at transaction level; responses are matched in issue order.
// Backpressure: response consumers are randomly, permanently or never ready depending on the phase.
module tb_bridge_arbiter;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] req0_addr = '0, req1_addr = '0;
  logic [DW-1:0] req0_data = '0, req1_data = '0;
  logic          req0_rw = 1'b0, req1_rw = 1'b0;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic          req0_ready, req1_ready;
  logic [DW-1:0] res0_data, res1_data;
  logic          res0_valid, res1_valid;
  logic          res0_ready = 1'b0, res1_ready = 1'b0;
  logic [AW-1:0] bus_addr_o;
  logic [DW-1:0] bus_data_o;
  logic          bus_rw_o, bus_valid_o;
  logic [DW-1:0] bus_data_i = '0;
  logic          bus_rw_i = 1'b0, bus_valid_i = 1'b0;
  logic [7:0]    timeout_count;

  bridge_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req0_addr(req0_addr), .req0_data(req0_data), .req0_rw(req0_rw), .req0_valid(req0_valid),
    .req0_ready(req0_ready), .res0_data(res0_data), .res0_valid(res0_valid), .res0_ready(res0_ready),
    .req1_addr(req1_addr), .req1_data(req1_data), .req1_rw(req1_rw), .req1_valid(req1_valid),
    .req1_ready(req1_ready), .res1_data(res1_data), .res1_valid(res1_valid), .res1_ready(res1_ready),
    .bus_addr_o(bus_addr_o), .bus_data_o(bus_data_o), .bus_rw_o(bus_rw_o), .bus_valid_o(bus_valid_o),
    .bus_data_i(bus_data_i), .bus_rw_i(bus_rw_i), .bus_valid_i(bus_valid_i),
    .timeout_count(timeout_count)
  );

  always #5 clk = ~clk;

  typedef struct { logic rw; logic [AW-1:0] addr; logic [DW-1:0] data; } req_t;
  typedef struct { int port; logic [DW-1:0] data; bit tout; } rsp_t;
  typedef struct { int d; logic rw; logic [DW-1:0] data; bit echo; } job_t;

  req_t pend0[$];
  req_t pend1[$];
  rsp_t rsp_q[$];
  job_t job_q[$];
  int   grant_log[$];

  int         checks = 0;
  int         errs   = 0;
  logic [7:0] exp_tcount = 8'd0;
  bit         favor = 1'b0;
  int         chain_d = -1;     // -1 random delay, 0 never respond, >0 fixed delay
  logic [DW-1:0] chain_dat = '0;
  int         rdy_mode = 1;     // 0 random, 1 always ready, 2 never ready

  logic          pv0 = 1'b0, pv1 = 1'b0, pbv = 1'b0;
  logic [AW-1:0] last_addr = '0;
  logic [DW-1:0] last_data = '0;
  logic          last_rw = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  task automatic send(input int port, input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_t r;
    int   n;
    logic rdy;
    r.rw = rw; r.addr = a; r.data = d;
    if (port == 0) begin
      pend0.push_back(r);
      req0_addr = a; req0_data = d; req0_rw = rw; req0_valid = 1'b1;
    end else begin
      pend1.push_back(r);
      req1_addr = a; req1_data = d; req1_rw = rw; req1_valid = 1'b1;
    end
    n = 0;
    rdy = 1'b0;
    while (!rdy && n < 400) begin
      @(posedge clk); #1;
      n++;
      rdy = (port == 0) ? req0_ready : req1_ready;
    end
    chk("req_accepted", 32'(rdy), 32'd1);
    if (port == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
  endtask

  task automatic port_rand(input int port, input int n);
    int gap;
    for (int i = 0; i < n; i++) begin
      send(port, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
      gap = $urandom_range(0, 3);
      repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((rsp_q.size() != 0 || pend0.size() != 0 || pend1.size() != 0) && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, 32'(rsp_q.size() + pend0.size() + pend1.size()), 32'd0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_req_ready"}, 32'({req1_ready, req0_ready}), 32'd0);
    chk({tag, "_res_valid"}, 32'({res1_valid, res0_valid}), 32'd0);
    chk({tag, "_res_data"},  32'({res1_data, res0_data}), 32'd0);
    chk({tag, "_bus_valid"}, 32'(bus_valid_o), 32'd0);
    chk({tag, "_bus_addr"},  32'(bus_addr_o), 32'd0);
    chk({tag, "_bus_data"},  32'(bus_data_o), 32'd0);
    chk({tag, "_bus_rw"},    32'(bus_rw_o), 32'd0);
    chk({tag, "_tcount"},    32'(timeout_count), 32'd0);
  endtask

  // Monitor: compares every cycle against the transaction-level model.
  task automatic monitor_cycle();
    int   w;
    int   avail;
    int   pick;
    req_t e;
    rsp_t r;
    job_t j;
    logic [DW-1:0] dat;
    logic [7:0]    texp;
    if (bus_valid_o) begin
      chk("strobe_spacing", 32'(pbv), 32'd0);
      if (pv0 && pv1) w = favor ? 1 : 0;
      else if (pv1) w = 1;
      else if (pv0) w = 0;
      else w = -1;
      chk("grant_ready", 32'({req1_ready, req0_ready}), (w == 1) ? 32'd2 : (w == 0) ? 32'd1 : 32'd0);
      grant_log.push_back(req1_ready ? 1 : 0);
      avail = (w == 0) ? pend0.size() : (w == 1) ? pend1.size() : 0;
      chk("grant_has_request", 32'(avail > 0), 32'd1);
      if (avail > 0) begin
        if (w == 0) e = pend0.pop_front(); else e = pend1.pop_front();
        chk("bus_addr", 32'(bus_addr_o), 32'(e.addr));
        chk("bus_data", 32'(bus_data_o), 32'(e.data));
        chk("bus_rw",   32'(bus_rw_o),   32'(e.rw));
        favor = (w == 0);
        last_addr = e.addr; last_data = e.data; last_rw = e.rw;
        if (e.rw) begin
          if ($urandom_range(0, 1) == 1) begin
            j.d = 1; j.rw = 1'b1; j.data = 16'($urandom); j.echo = 1'b0;
            job_q.push_back(j);
          end
        end else begin
          if (chain_d < 0) begin
            pick = $urandom_range(0, TO + 1);
            dat  = 16'($urandom);
          end else begin
            pick = chain_d;
            dat  = chain_dat;
          end
          r.port = w;
          r.tout = !(pick >= 1 && pick <= TO);
          r.data = r.tout ? '0 : dat;
          rsp_q.push_back(r);
          if (pick > 0) begin
            j.d = pick; j.rw = 1'b0; j.data = dat;
            j.echo = (chain_d < 0) && (pick >= 2) && ($urandom_range(0, 1) == 1);
            job_q.push_back(j);
          end
        end
      end
    end else begin
      chk("ready_idle", 32'({req1_ready, req0_ready}), 32'd0);
      chk("bus_addr_hold", 32'(bus_addr_o), 32'(last_addr));
      chk("bus_data_hold", 32'(bus_data_o), 32'(last_data));
      chk("bus_rw_hold",   32'(bus_rw_o),   32'(last_rw));
    end

    if (res0_valid || res1_valid) begin
      chk("res_onehot", 32'(res0_valid & res1_valid), 32'd0);
      chk("res_expected", 32'(rsp_q.size() > 0), 32'd1);
      if (rsp_q.size() > 0) begin
        r = rsp_q[0];
        texp = r.tout ? sat_inc(exp_tcount) : exp_tcount;
        chk("res_port", res1_valid ? 32'd1 : 32'd0, 32'(r.port));
        chk("res_data", res1_valid ? 32'(res1_data) : 32'(res0_data), 32'(r.data));
        chk("timeout_count", 32'(timeout_count), 32'(texp));
        if (res1_valid ? res1_ready : res0_ready) begin
          r = rsp_q.pop_front();
          exp_tcount = texp;
        end
      end
    end else begin
      chk("timeout_count_idle", 32'(timeout_count), 32'(exp_tcount));
    end
    pv0 = req0_valid; pv1 = req1_valid; pbv = bus_valid_o;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        pv0 = 1'b0; pv1 = 1'b0; pbv = 1'b0; favor = 1'b0;
        last_addr = '0; last_data = '0; last_rw = 1'b0;
      end else begin
        monitor_cycle();
      end
    end
  end

  // Core chain model: replays planned responses, echoes and stray strobes.
  initial begin
    job_t j;
    forever begin
      @(posedge clk);
      if (job_q.size() > 0 && !rst) begin
        j = job_q.pop_front();
        for (int c = 1; c <= j.d; c++) begin
          if (c > 1) @(posedge clk);
          #1;
          if (c == j.d) begin
            bus_valid_i = 1'b1; bus_rw_i = j.rw; bus_data_i = j.data;
          end else if (c == 1 && j.echo) begin
            bus_valid_i = 1'b1; bus_rw_i = 1'b1; bus_data_i = 16'($urandom);
          end else begin
            bus_valid_i = 1'b0;
          end
        end
        @(posedge clk); #1;
        bus_valid_i = 1'b0; bus_rw_i = 1'b0;
      end
    end
  end

  // Response consumer readiness.
  initial begin
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       begin res0_ready = 1'($urandom_range(0, 1)); res1_ready = 1'($urandom_range(0, 1)); end
        1:       begin res0_ready = 1'b1; res1_ready = 1'b1; end
        default: begin res0_ready = 1'b0; res1_ready = 1'b0; end
      endcase
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Port 0 write.
    send(0, 1'b1, 16'h0012, 16'hBEEF);
    chk("wr_bus_valid", 32'(bus_valid_o), 32'd1);
    chk("wr_bus_addr",  32'(bus_addr_o), 32'h0012);
    chk("wr_bus_data",  32'(bus_data_o), 32'hBEEF);
    chk("wr_bus_rw",    32'(bus_rw_o), 32'd1);
    @(posedge clk); #1;
    chk("wr_strobe_len", 32'({bus_valid_o, req0_ready}), 32'd0);
    repeat (3) @(posedge clk); #1;
    chk("wr_no_res", 32'({res1_valid, res0_valid}), 32'd0);

    // Port 1 read answered three cycles after the strobe, consumer stalled.
    rdy_mode = 2; chain_d = 3; chain_dat = 16'h1234;
    send(1, 1'b0, 16'h0004, 16'h0000);
    n = 0;
    while (!res1_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk("rd_latency", 32'(n), 32'd4);
    repeat (3) begin
      chk("rd_hold_valid", 32'(res1_valid), 32'd1);
      chk("rd_hold_data",  32'(res1_data), 32'h1234);
      chk("rd_res0_quiet", 32'(res0_valid), 32'd0);
      @(posedge clk); #1;
    end
    rdy_mode = 1;
    repeat (3) @(posedge clk); #1;
    chk("rd_released", 32'(res1_valid), 32'd0);

    // Tie twice: alternation 0,1,0,1.
    grant_log.delete();
    fork
      send(0, 1'b1, 16'h0100, 16'h1111);
      send(1, 1'b1, 16'h0101, 16'h2222);
    join
    fork
      send(0, 1'b1, 16'h0102, 16'h3333);
      send(1, 1'b1, 16'h0103, 16'h4444);
    join
    repeat (3) @(posedge clk); #1;
    chk("tie_count", 32'(grant_log.size()), 32'd4);
    if (grant_log.size() == 4) begin
      chk("tie_order0", 32'(grant_log[0]), 32'd0);
      chk("tie_order1", 32'(grant_log[1]), 32'd1);
      chk("tie_order2", 32'(grant_log[2]), 32'd0);
      chk("tie_order3", 32'(grant_log[3]), 32'd1);
    end

    // Read timeout, then response coinciding with the final wait cycle.
    chain_d = 0;
    send(0, 1'b0, 16'h0040, 16'h0000);
    n = 0;
    while (!res0_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk("to_latency", 32'(n), 32'(TO + 1));
    chk("to_data",    32'(res0_data), 32'd0);
    chk("to_count",   32'(timeout_count), 32'd1);
    chain_d = TO; chain_dat = 16'h5A5A;
    send(1, 1'b0, 16'h0041, 16'h0000);
    n = 0;
    while (!res1_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk("coinc_data",  32'(res1_data), 32'h5A5A);
    chk("coinc_count", 32'(timeout_count), 32'd1);
    wait_drain("drain_directed");

    // Random traffic on both ports.
    rdy_mode = 0; chain_d = -1;
    fork
      port_rand(0, 40);
      port_rand(1, 40);
    join
    rdy_mode = 1;
    wait_drain("drain_random");

    // Saturate the timeout counter.
    chain_d = 0;
    for (int i = 0; i < 256; i++) send(0, 1'b0, 16'(i), 16'h0000);
    wait_drain("drain_saturate");
    chk("tcount_saturated", 32'(timeout_count), 32'd255);

    // Reset during WAIT_RESP, then a stray late response.
    send(0, 1'b0, 16'h0077, 16'h0000);
    @(posedge clk); #1;
    rst = 1'b1;
    rsp_q.delete(); job_q.delete(); pend0.delete(); pend1.delete();
    exp_tcount = 8'd0;
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    begin
      job_t j;
      j.d = 1; j.rw = 1'b0; j.data = 16'hAAAA; j.echo = 1'b0;
      job_q.push_back(j);
    end
    repeat (4) @(posedge clk); #1;
    check_zero("post_reset");
    chain_d = -1;
    grant_log.delete();
    fork
      send(0, 1'b1, 16'h0200, 16'h5555);
      send(1, 1'b1, 16'h0201, 16'h6666);
    join
    repeat (3) @(posedge clk); #1;
    chk("rst_tie_count", 32'(grant_log.size()), 32'd2);
    if (grant_log.size() == 2) begin
      chk("rst_tie_first", 32'(grant_log[0]), 32'd0);
      chk("rst_tie_second", 32'(grant_log[1]), 32'd1);
    end
    wait_drain("drain_final");

    $display("== %0d vectors applied, %0d miscompares ==", checks, errs);
    $finish;
  end

endmodule
